// File: rtl/bram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_frame_reader
// Purpose  : Reads a frame from a circular BRAM region into a valid/ready
//            stream with last-beat marking. Optional abort: READER_ABORT_EN.
// Revision : 1.0
// ============================================================================
module bram_frame_reader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_len,
`ifdef READER_ABORT_EN
    input  logic              i_abort,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rden,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tvalid,
    output logic              o_tlast,
    input  logic              i_tready
);

    localparam logic [ADDR_W-1:0] c_ADDR_MAX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_rd_cnt;
    logic               r_inflight;
    logic               r_inflight_last;
    logic [DATA_W-1:0]  r_mem_data [2];
    logic               r_mem_last [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic               r_done;

    logic               w_abort;
    logic               w_hs;
    logic               w_last_rd;
    logic               w_room;
    logic [2:0]         w_occ;
    logic               w_rden;
    logic               w_done_nxt;
    logic               w_flush;
    logic               w_load;
    logic [ADDR_W-1:0]  w_addr_inc;

`ifdef READER_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    assign o_tvalid   = (r_count != 2'd0);
    assign o_tdata    = r_mem_data[r_rd_ptr];
    assign o_tlast    = o_tvalid & r_mem_last[r_rd_ptr];
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_rden     = w_rden;
    assign o_raddr    = r_addr;

    assign w_hs       = o_tvalid & i_tready;
    assign w_last_rd  = (r_rd_cnt == (r_len - LEN_W'(1)));
    // A word leaving this cycle frees its slot, which keeps 1 word/clk.
    assign w_occ      = 3'(r_count) + 3'(r_inflight) - 3'(w_hs);
    assign w_room     = (w_occ < 3'd2);
    assign w_load     = (r_state == S_IDLE) && i_start && (i_len != '0);
    assign w_addr_inc = (r_addr == c_ADDR_MAX) ? '0 : r_addr + ADDR_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rden      = 1'b0;
        w_done_nxt  = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        w_state_nxt = S_READ;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_flush     = 1'b1;
                    w_done_nxt  = 1'b1;
                end else if (w_room) begin
                    w_rden = 1'b1;
                    if (w_last_rd) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_flush     = 1'b1;
                    w_done_nxt  = 1'b1;
                end else if (w_hs && o_tlast) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr          <= '0;
            r_len           <= '0;
            r_rd_cnt        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_mem_data[0]   <= '0;
            r_mem_data[1]   <= '0;
            r_mem_last[0]   <= 1'b0;
            r_mem_last[1]   <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
            r_done          <= 1'b0;
        end else begin
            r_done <= w_done_nxt;

            if (w_load) begin
                r_addr   <= i_base_addr;
                r_len    <= i_len;
                r_rd_cnt <= '0;
            end else if (w_rden) begin
                r_addr   <= w_addr_inc;
                r_rd_cnt <= r_rd_cnt + LEN_W'(1);
            end

            r_inflight      <= w_rden;
            r_inflight_last <= w_last_rd;

            // Abort drops both the queued words and the read still in the BRAM pipe.
            if (w_flush) begin
                r_count    <= 2'd0;
                r_wr_ptr   <= 1'b0;
                r_rd_ptr   <= 1'b0;
                r_inflight <= 1'b0;
            end else begin
                if (r_inflight) begin
                    r_mem_data[r_wr_ptr] <= i_rdata;
                    r_mem_last[r_wr_ptr] <= r_inflight_last;
                    r_wr_ptr             <= ~r_wr_ptr;
                end
                if (w_hs) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= r_count + 2'(r_inflight) - 2'(w_hs);
            end
        end
    end

endmodule
`default_nettype wire
